// File: rtl/scc68070_pkg.sv
// Shared types and constants for the SCC68070 timer unit.
// Capture support is selected by the SCC68070_TIMER_CAPTURE_EN macro.
package scc68070_pkg;

  typedef enum logic [1:0] {
    INHIBIT = 2'b00,
    MATCH   = 2'b01,
    CAPTURE = 2'b10,
    EVENT   = 2'b11
  } timer_mode_t;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } timer_edge_t;

  typedef struct packed {
    logic t0_ov;
    logic t1_ma;
    logic t1_cap;
    logic t1_ov;
    logic t2_ma;
    logic t2_cap;
    logic t2_ov;
    logic reserved;
  } timer_status_t;

  typedef struct packed {
    timer_edge_t t1_event;
    timer_mode_t t1_mode;
    timer_edge_t t2_event;
    timer_mode_t t2_mode;
  } timer_control_t;

  localparam logic [2:0] TIMER_REG_STATUS = 3'd0;
  localparam logic [2:0] TIMER_REG_RELOAD = 3'd1;
  localparam logic [2:0] TIMER_REG_T0     = 3'd2;
  localparam logic [2:0] TIMER_REG_T1     = 3'd3;
  localparam logic [2:0] TIMER_REG_T2     = 3'd4;

  // Replace only the byte lanes enabled for this write.
  function automatic logic [15:0] merge_bytes(input logic [15:0] cur,
                                              input logic [15:0] wdata,
                                              input logic        hi,
                                              input logic        lo);
    return {hi ? wdata[15:8] : cur[15:8], lo ? wdata[7:0] : cur[7:0]};
  endfunction

  // Status bits that physically exist for a given channel count / capture build.
  function automatic logic [7:0] status_mask(input int num_ch, input bit cap_en);
    logic [7:0] m;
    m = 8'h80;
    if (num_ch >= 1) m = m | 8'h70;
    if (num_ch >= 2) m = m | 8'h0E;
    if (!cap_en)     m = m & 8'hDB;
    return m;
  endfunction

  function automatic logic [7:0] control_mask(input int num_ch);
    logic [7:0] m;
    m = 8'h00;
    if (num_ch >= 1) m = m | 8'hF0;
    if (num_ch >= 2) m = m | 8'h0F;
    return m;
  endfunction

endpackage

// File: rtl/scc68070_timer_channel.sv
// One match/capture/event channel (T1 or T2): pin synchroniser, edge detect and TN.
// Capture mode exists only when SCC68070_TIMER_CAPTURE_EN is defined.
module scc68070_timer_channel
  import scc68070_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        event_in,
  input  logic [1:0]  mode,
  input  logic [1:0]  edge_sel,
  input  logic [15:0] t0_value,
  input  logic [15:0] t0_next,
  input  logic        t0_tick,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [15:0] wdata,
  output logic [15:0] tn,
  output logic        set_ma,
  output logic        set_cap,
  output logic        set_ov
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   edge_q;
  logic                   edge_det;
  logic                   rise;
  logic                   fall;
  logic [15:0]            tn_q;
  logic [15:0]            tn_hw;

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;

  // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    edge_det = 1'b0;
    case (timer_edge_t'(edge_sel))
      EDGE_NONE: edge_det = 1'b0;
      EDGE_RISE: edge_det = rise;
      EDGE_FALL: edge_det = fall;
      EDGE_BOTH: edge_det = rise | fall;
    endcase
  end

  always_comb begin
    tn_hw   = tn_q;
    set_ma  = 1'b0;
    set_cap = 1'b0;
    set_ov  = 1'b0;
    case (timer_mode_t'(mode))
      MATCH: begin
        if (t0_tick && (t0_next == tn_q)) set_ma = 1'b1;
      end
`ifdef SCC68070_TIMER_CAPTURE_EN
      CAPTURE: begin
        if (edge_q) begin
          tn_hw   = t0_value;
          set_cap = 1'b1;
        end
      end
`endif
      EVENT: begin
        if (edge_q) begin
          tn_hw  = tn_q + 16'd1;
          set_ov = (tn_q == 16'hFFFF);
        end
      end
      default: ;
    endcase
  end

`ifndef SCC68070_TIMER_CAPTURE_EN
  logic unused_t0_value;
  assign unused_t0_value = ^t0_value;
`endif

  // The qualified edge is registered so TN reacts SYNC_STAGES+1 clocks after the pin is sampled.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
      tn_q   <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], event_in};
      prev_q <= sync_q[SYNC_STAGES-1];
      edge_q <= edge_det;
      tn_q   <= merge_bytes(tn_hw, wdata, wr_hi, wr_lo);
    end
  end

  assign tn = tn_q;

endmodule

// File: rtl/scc68070_timer.sv
// SCC68070 timer unit: prescaler, reload timer T0, W1C status, control and read mux.
// Define SCC68070_TIMER_CAPTURE_EN to build the capture mode of the channels.
module scc68070_timer
  import scc68070_pkg::*;
#(
  parameter int PRESCALE    = 96,
  parameter int NUM_CH      = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 stb,
  input  logic                                 wr,
  input  logic                                 uds,
  input  logic                                 lds,
  input  logic [2:0]                           reg_sel,
  input  logic [15:0]                          wdata,
  output logic [15:0]                          rdata,
  input  logic [(NUM_CH > 1 ? NUM_CH : 1)-1:0] event_in,
  output logic                                 irq,
  output logic                                 t0_tick
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
`ifdef SCC68070_TIMER_CAPTURE_EN
  localparam bit CAP_EN = 1'b1;
`else
  localparam bit CAP_EN = 1'b0;
`endif
  localparam logic [7:0] STATUS_MASK  = status_mask(NUM_CH, CAP_EN);
  localparam logic [7:0] CONTROL_MASK = control_mask(NUM_CH);

  logic [PW-1:0]  presc_q;
  logic [15:0]    t0_q;
  logic [15:0]    reload_q;
  logic [15:0]    t0_next;
  timer_status_t  status_q;
  timer_status_t  status_set;
  logic [7:0]     status_clr;
  timer_control_t control_q;

  logic wr_en, sel_status, sel_reload, t0_wr, terminal, t0_wrap;

  logic [15:0] ch_tn   [2];
  logic [1:0]  ch_mode [2];
  logic [1:0]  ch_edge [2];
  logic        ch_ma   [2];
  logic        ch_cap  [2];
  logic        ch_ov   [2];

  assign wr_en      = stb & wr;
  assign sel_status = wr_en & (reg_sel == TIMER_REG_STATUS);
  assign sel_reload = wr_en & (reg_sel == TIMER_REG_RELOAD);
  assign t0_wr      = wr_en & (reg_sel == TIMER_REG_T0) & (uds | lds);

  // A CPU write to T0 restarts the prescaler and suppresses the tick of that cycle.
  assign terminal = (presc_q == PS_LAST);
  assign t0_tick  = terminal & ~t0_wr;
  assign t0_wrap  = t0_tick & (t0_q == 16'hFFFF);
  assign t0_next  = t0_wrap ? reload_q : t0_q + 16'd1;

  assign ch_mode[0] = control_q.t1_mode;
  assign ch_edge[0] = control_q.t1_event;
  assign ch_mode[1] = control_q.t2_mode;
  assign ch_edge[1] = control_q.t2_event;

  for (genvar i = 0; i < 2; i++) begin : g_ch
    if (i < NUM_CH) begin : g_on
      logic ch_sel;
      assign ch_sel = wr_en & (reg_sel == ((i == 0) ? TIMER_REG_T1 : TIMER_REG_T2));

      scc68070_timer_channel #(
        .SYNC_STAGES(SYNC_STAGES)
      ) u_channel (
        .clk     (clk),
        .reset   (reset),
        .event_in(event_in[i]),
        .mode    (ch_mode[i]),
        .edge_sel(ch_edge[i]),
        .t0_value(t0_q),
        .t0_next (t0_next),
        .t0_tick (t0_tick),
        .wr_hi   (ch_sel & uds),
        .wr_lo   (ch_sel & lds),
        .wdata   (wdata),
        .tn      (ch_tn[i]),
        .set_ma  (ch_ma[i]),
        .set_cap (ch_cap[i]),
        .set_ov  (ch_ov[i])
      );
    end else begin : g_off
      assign ch_tn[i]  = '0;
      assign ch_ma[i]  = 1'b0;
      assign ch_cap[i] = 1'b0;
      assign ch_ov[i]  = 1'b0;
    end
  end

  always_comb begin
    status_set        = '0;
    status_set.t0_ov  = t0_wrap;
    status_set.t1_ma  = ch_ma[0];
    status_set.t1_cap = ch_cap[0];
    status_set.t1_ov  = ch_ov[0];
    status_set.t2_ma  = ch_ma[1];
    status_set.t2_cap = ch_cap[1];
    status_set.t2_ov  = ch_ov[1];
  end

  assign status_clr = (sel_status && uds) ? wdata[15:8] : 8'h00;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q   <= '0;
      t0_q      <= '0;
      reload_q  <= '0;
      status_q  <= '0;
      control_q <= '0;
    end else begin
      if (t0_wr || terminal) presc_q <= '0;
      else                   presc_q <= presc_q + PW'(1);

      if (t0_wr)        t0_q <= merge_bytes(t0_q, wdata, uds, lds);
      else if (t0_tick) t0_q <= t0_next;

      if (sel_reload) reload_q <= merge_bytes(reload_q, wdata, uds, lds);

      if (sel_status && lds) control_q <= timer_control_t'(wdata[7:0] & CONTROL_MASK);

      // Set is OR-ed in after the clear, so a coincident set wins.
      status_q <= timer_status_t'(((status_q & ~status_clr) | status_set) & STATUS_MASK);
    end
  end

  assign irq = |status_q;

  always_comb begin
    rdata = '0;
    case (reg_sel)
      TIMER_REG_STATUS: rdata = {status_q, control_q};
      TIMER_REG_RELOAD: rdata = reload_q;
      TIMER_REG_T0:     rdata = t0_q;
      TIMER_REG_T1:     rdata = ch_tn[0];
      TIMER_REG_T2:     rdata = ch_tn[1];
      default:          rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_scc68070_timer.sv
// Directed self-checking bench for scc68070_timer (default parameters).
// Expectations for capture mode follow whether SCC68070_TIMER_CAPTURE_EN is defined.
module tb_scc68070_timer;

  localparam int PRESCALE    = 96;
  localparam int NUM_CH      = 2;
  localparam int SYNC_STAGES = 2;
`ifdef SCC68070_TIMER_CAPTURE_EN
  localparam bit CAP_EN = 1'b1;
`else
  localparam bit CAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stb = 1'b0;
  logic        wr = 1'b0;
  logic        uds = 1'b0;
  logic        lds = 1'b0;
  logic [2:0]  reg_sel = 3'd0;
  logic [15:0] wdata = 16'h0000;
  logic [15:0] rdata;
  logic [1:0]  event_in = 2'b00;
  logic        irq;
  logic        t0_tick;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  scc68070_timer #(
    .PRESCALE   (PRESCALE),
    .NUM_CH     (NUM_CH),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .stb     (stb),
    .wr      (wr),
    .uds     (uds),
    .lds     (lds),
    .reg_sel (reg_sel),
    .wdata   (wdata),
    .rdata   (rdata),
    .event_in(event_in),
    .irq     (irq),
    .t0_tick (t0_tick)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [2:0] sel, input logic [15:0] d, input logic u, input logic l);
    reg_sel = sel;
    wdata   = d;
    uds     = u;
    lds     = l;
    wr      = 1'b1;
    stb     = 1'b1;
    @(posedge clk);
    #1;
    stb = 1'b0;
    wr  = 1'b0;
    uds = 1'b0;
    lds = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] sel, input logic [15:0] exp);
    reg_sel = sel;
    #1;
    check(tag, rdata, exp);
  endtask

  initial begin
    // Reset state
    step(3);
    reset = 1'b0;
    rd_chk("rst_reg0", 3'd0, 16'h0000);
    rd_chk("rst_reload", 3'd1, 16'h0000);
    rd_chk("rst_t0", 3'd2, 16'h0000);
    rd_chk("rst_t1", 3'd3, 16'h0000);
    rd_chk("rst_t2", 3'd4, 16'h0000);
    check("rst_irq", {15'd0, irq}, 16'h0000);
    check("rst_tick", {15'd0, t0_tick}, 16'h0000);

    // T0 overflow with reload
    wr_reg(3'd1, 16'hFF00, 1'b1, 1'b1);
    wr_reg(3'd2, 16'hFFFE, 1'b1, 1'b1);
    step(95);
    check("ov_tick_pulse", {15'd0, t0_tick}, 16'h0001);
    rd_chk("ov_t0_before", 3'd2, 16'hFFFE);
    step(1);
    rd_chk("ov_t0_ffff", 3'd2, 16'hFFFF);
    step(95);
    check("ov_irq_early", {15'd0, irq}, 16'h0000);
    step(1);
    check("ov_irq", {15'd0, irq}, 16'h0001);
    rd_chk("ov_status", 3'd0, 16'h8000);
    rd_chk("ov_t0_reload", 3'd2, 16'hFF00);
    wr_reg(3'd0, 16'h8000, 1'b1, 1'b0);
    check("ov_irq_cleared", {15'd0, irq}, 16'h0000);
    rd_chk("ov_status_cleared", 3'd0, 16'h0000);

    // Match on T1
    wr_reg(3'd0, 16'h0010, 1'b0, 1'b1);
    wr_reg(3'd3, 16'h0005, 1'b1, 1'b1);
    wr_reg(3'd2, 16'h0000, 1'b1, 1'b1);
    step(479);
    rd_chk("ma_early", 3'd0, 16'h0010);
    check("ma_irq_early", {15'd0, irq}, 16'h0000);
    step(1);
    rd_chk("ma_status", 3'd0, 16'h4010);
    rd_chk("ma_t0", 3'd2, 16'h0005);
    check("ma_irq", {15'd0, irq}, 16'h0001);
    wr_reg(3'd0, 16'h4000, 1'b1, 1'b1);
    rd_chk("ma_cleared", 3'd0, 16'h0000);

    // Capture on T2, rising edge only
    wr_reg(3'd0, 16'h0006, 1'b0, 1'b1);
    wr_reg(3'd4, 16'h00AA, 1'b1, 1'b1);
    wr_reg(3'd2, 16'h1234, 1'b1, 1'b1);
    event_in[1] = 1'b1;
    step(3);
    rd_chk("cap_t2_early", 3'd4, 16'h00AA);
    rd_chk("cap_status_early", 3'd0, 16'h0006);
    step(1);
    rd_chk("cap_t2", 3'd4, CAP_EN ? 16'h1234 : 16'h00AA);
    rd_chk("cap_status", 3'd0, CAP_EN ? 16'h0406 : 16'h0006);
    wr_reg(3'd2, 16'h5678, 1'b1, 1'b1);
    event_in[1] = 1'b0;
    step(6);
    rd_chk("cap_fall_t2", 3'd4, CAP_EN ? 16'h1234 : 16'h00AA);
    rd_chk("cap_fall_status", 3'd0, CAP_EN ? 16'h0406 : 16'h0006);
    wr_reg(3'd0, 16'h0400, 1'b1, 1'b1);
    rd_chk("cap_cleared", 3'd0, 16'h0000);
    check("cap_irq_cleared", {15'd0, irq}, 16'h0000);

    // Event count on T1, both edges, wrap
    wr_reg(3'd0, 16'h00F0, 1'b0, 1'b1);
    wr_reg(3'd3, 16'hFFFE, 1'b1, 1'b1);
    event_in[0] = 1'b1;
    step(4);
    rd_chk("evt_t1_ffff", 3'd3, 16'hFFFF);
    rd_chk("evt_status_noov", 3'd0, 16'h00F0);
    event_in[0] = 1'b0;
    step(4);
    rd_chk("evt_t1_wrap", 3'd3, 16'h0000);
    rd_chk("evt_status_ov", 3'd0, 16'h10F0);
    check("evt_irq", {15'd0, irq}, 16'h0001);
    wr_reg(3'd0, 16'h1000, 1'b1, 1'b1);
    rd_chk("evt_cleared", 3'd0, 16'h0000);
    wr_reg(3'd3, 16'hAA34, 1'b0, 1'b1);
    rd_chk("byte_lo", 3'd3, 16'h0034);
    wr_reg(3'd3, 16'h12BB, 1'b1, 1'b0);
    rd_chk("byte_hi", 3'd3, 16'h1234);

    // Set wins over a coincident W1C
    wr_reg(3'd2, 16'hFFFF, 1'b1, 1'b1);
    step(95);
    wr_reg(3'd0, 16'h8000, 1'b1, 1'b0);
    rd_chk("setwins_status", 3'd0, 16'h8000);
    rd_chk("setwins_t0", 3'd2, 16'hFF00);
    check("setwins_irq", {15'd0, irq}, 16'h0001);

    // Unused register location
    wr_reg(3'd5, 16'hFFFF, 1'b1, 1'b1);
    rd_chk("unused_reg5", 3'd5, 16'h0000);

    // Reset mid-count
    wr_reg(3'd1, 16'h1111, 1'b1, 1'b1);
    wr_reg(3'd0, 16'h0055, 1'b0, 1'b1);
    wr_reg(3'd4, 16'hBEEF, 1'b1, 1'b1);
    wr_reg(3'd2, 16'h0100, 1'b1, 1'b1);
    step(50);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    rd_chk("mid_reg0", 3'd0, 16'h0000);
    rd_chk("mid_reload", 3'd1, 16'h0000);
    rd_chk("mid_t0", 3'd2, 16'h0000);
    rd_chk("mid_t1", 3'd3, 16'h0000);
    rd_chk("mid_t2", 3'd4, 16'h0000);
    check("mid_irq", {15'd0, irq}, 16'h0000);
    check("mid_tick", {15'd0, t0_tick}, 16'h0000);
    step(95);
    rd_chk("mid_t0_hold", 3'd2, 16'h0000);
    check("mid_tick_first", {15'd0, t0_tick}, 16'h0001);
    step(1);
    rd_chk("mid_t0_first", 3'd2, 16'h0001);
    check("mid_irq_after", {15'd0, irq}, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
